// File: rtl/riscv_writeback.sv
// Writeback stage: drives the register-file write port, merging execute results
// with queued memory results, and provides bypass/pending checks to issue.
module riscv_writeback #(
  parameter int unsigned MEM_FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exec_valid_i,
  input  logic [4:0]  exec_rd_i,
  input  logic [31:0] exec_value_i,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_rd_i,
  input  logic [31:0] mem_value_i,
  output logic        mem_ready_o,
  output logic        exec_stall_o,
  output logic [4:0]  rd0_o,
  output logic [31:0] rd0_value_o,
  input  logic [4:0]  ra0_i,
  input  logic [4:0]  rb0_i,
  output logic        ra0_fwd_o,
  output logic        rb0_fwd_o,
  input  logic [4:0]  issue_rd_i,
  output logic        ra0_pend_o,
  output logic        rb0_pend_o,
  output logic        rd_pend_o
);

  localparam int unsigned PTR_W  = $clog2(MEM_FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = 8;

  logic [4:0]                fifo_rd_q  [MEM_FIFO_DEPTH];
  logic [31:0]               fifo_val_q [MEM_FIFO_DEPTH];
  logic [MEM_FIFO_DEPTH-1:0] fifo_vld_q;
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          count_q, count_next;
  logic [WAIT_W-1:0]         wait_q, wait_next;
  logic                      ready_q, stall_q, stall_next;
  logic [4:0]                rd0_q, rd0_next;
  logic [31:0]               val_q, val_next;
  logic                      exec_sel, fifo_empty, push, pop;

  // Source select, FIFO occupancy and starvation tracking
  always_comb begin
    exec_sel   = exec_valid_i && (exec_rd_i != 5'd0);
    fifo_empty = (count_q == '0);
    push       = mem_valid_i && ready_q && (mem_rd_i != 5'd0);
    pop        = !exec_sel && !fifo_empty;
    count_next = count_q + CNT_W'(push) - CNT_W'(pop);

    wait_next = wait_q;
    if (pop || fifo_empty) wait_next = '0;
    else if (wait_q != '1) wait_next = wait_q + WAIT_W'(1);

    stall_next = !fifo_empty && !pop && (wait_q >= WAIT_W'(STARVE_LIMIT - 1));

    rd0_next = 5'd0;
    val_next = 32'd0;
    if (exec_sel) begin
      rd0_next = exec_rd_i;
      val_next = exec_value_i;
    end else if (!fifo_empty) begin
      rd0_next = fifo_rd_q[rd_ptr_q];
      val_next = fifo_val_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      ready_q    <= 1'b1;
      stall_q    <= 1'b0;
      rd0_q      <= 5'd0;
      val_q      <= 32'd0;
    end else begin
      if (push) begin
        fifo_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        fifo_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q             <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_next;
      wait_q  <= wait_next;
      ready_q <= (count_next != CNT_W'(MEM_FIFO_DEPTH));
      stall_q <= stall_next;
      rd0_q   <= rd0_next;
      val_q   <= val_next;
    end
  end

  // Entry payload needs no reset; validity is tracked in fifo_vld_q
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]  <= mem_rd_i;
      fifo_val_q[wr_ptr_q] <= mem_value_i;
    end
  end

  // Pending-destination search over live FIFO entries
  always_comb begin
    ra0_pend_o = 1'b0;
    rb0_pend_o = 1'b0;
    rd_pend_o  = 1'b0;
    for (int i = 0; i < int'(MEM_FIFO_DEPTH); i++) begin
      if (fifo_vld_q[i]) begin
        if (ra0_i != 5'd0 && fifo_rd_q[i] == ra0_i)      ra0_pend_o = 1'b1;
        if (rb0_i != 5'd0 && fifo_rd_q[i] == rb0_i)      rb0_pend_o = 1'b1;
        if (issue_rd_i != 5'd0 && fifo_rd_q[i] == issue_rd_i) rd_pend_o = 1'b1;
      end
    end
  end

  assign mem_ready_o  = ready_q;
  assign exec_stall_o = stall_q;
  assign rd0_o        = rd0_q;
  assign rd0_value_o  = val_q;
  assign ra0_fwd_o    = (rd0_q != 5'd0) && (rd0_q == ra0_i);
  assign rb0_fwd_o    = (rd0_q != 5'd0) && (rd0_q == rb0_i);

  // Upstream must honour the stall; exec still wins if it does not
  always @(posedge clk) begin
    if (!rst && stall_q)
      assert (!exec_sel) else $error("exec result presented while exec_stall_o was set");
  end

endmodule

// File: tb/tb_riscv_writeback.sv
// Directed testbench for riscv_writeback: one task per scenario, inline checks.
module tb_riscv_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        exec_valid_i;
  logic [4:0]  exec_rd_i;
  logic [31:0] exec_value_i;
  logic        mem_valid_i;
  logic [4:0]  mem_rd_i;
  logic [31:0] mem_value_i;
  logic        mem_ready_o;
  logic        exec_stall_o;
  logic [4:0]  rd0_o;
  logic [31:0] rd0_value_o;
  logic [4:0]  ra0_i, rb0_i, issue_rd_i;
  logic        ra0_fwd_o, rb0_fwd_o;
  logic        ra0_pend_o, rb0_pend_o, rd_pend_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  riscv_writeback #(.MEM_FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .exec_valid_i(exec_valid_i), .exec_rd_i(exec_rd_i), .exec_value_i(exec_value_i),
    .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_value_i(mem_value_i),
    .mem_ready_o(mem_ready_o), .exec_stall_o(exec_stall_o),
    .rd0_o(rd0_o), .rd0_value_o(rd0_value_o),
    .ra0_i(ra0_i), .rb0_i(rb0_i),
    .ra0_fwd_o(ra0_fwd_o), .rb0_fwd_o(rb0_fwd_o),
    .issue_rd_i(issue_rd_i),
    .ra0_pend_o(ra0_pend_o), .rb0_pend_o(rb0_pend_o), .rd_pend_o(rd_pend_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exec_valid_i = 1'b0; exec_rd_i = 5'd0; exec_value_i = 32'd0;
    mem_valid_i  = 1'b0; mem_rd_i  = 5'd0; mem_value_i  = 32'd0;
    ra0_i = 5'd0; rb0_i = 5'd0; issue_rd_i = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    total_cnt++;
    if (rd0_o !== 5'd0 || rd0_value_o !== 32'd0 || exec_stall_o !== 1'b0 || mem_ready_o !== 1'b1) begin
      $display("FAIL reset_state: rd0=%0d val=%h stall=%b ready=%b, want 0 0 0 1",
               rd0_o, rd0_value_o, exec_stall_o, mem_ready_o);
    end else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_exec();
    exec_valid_i = 1'b1; exec_rd_i = 5'd5; exec_value_i = 32'h1234;
    tick();
    total_cnt++;
    if (rd0_o !== 5'd5 || rd0_value_o !== 32'h1234) begin
      $display("FAIL exec_write: rd0=%0d val=%h, want 5 00001234", rd0_o, rd0_value_o);
    end else pass_cnt++;
    exec_valid_i = 1'b0;
    tick();
    total_cnt++;
    if (rd0_o !== 5'd0 || rd0_value_o !== 32'd0) begin
      $display("FAIL exec_idle: rd0=%0d val=%h, want 0 0", rd0_o, rd0_value_o);
    end else pass_cnt++;
    // exec_valid with rd=0 writes nothing
    exec_valid_i = 1'b1; exec_rd_i = 5'd0; exec_value_i = 32'hDEAD;
    tick();
    total_cnt++;
    if (rd0_o !== 5'd0) $display("FAIL exec_rd0: rd0=%0d, want 0", rd0_o);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_mem_single();
    mem_valid_i = 1'b1; mem_rd_i = 5'd7; mem_value_i = 32'hAA;
    tick();
    mem_valid_i = 1'b0;
    total_cnt++;
    if (rd0_o !== 5'd0) $display("FAIL mem_no_passthru: rd0=%0d, want 0", rd0_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rd0_o !== 5'd7 || rd0_value_o !== 32'hAA) begin
      $display("FAIL mem_write: rd0=%0d val=%h, want 7 000000aa", rd0_o, rd0_value_o);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (rd0_o !== 5'd0) $display("FAIL mem_drained: rd0=%0d, want 0", rd0_o);
    else pass_cnt++;
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 4; i++) begin
      exec_valid_i = 1'b1; exec_rd_i = 5'd1; exec_value_i = 32'(i);
      mem_valid_i  = 1'b1; mem_rd_i  = 5'(10 + i); mem_value_i = 32'h100 + 32'(i);
      tick();
      total_cnt++;
      if (mem_ready_o !== (i < 3)) $display("FAIL fill_ready%0d: ready=%b, want %b", i, mem_ready_o, (i < 3));
      else pass_cnt++;
    end
    total_cnt++;
    if (rd0_o !== 5'd1 || rd0_value_o !== 32'd3) $display("FAIL fill_exec: rd0=%0d val=%h, want 1 3", rd0_o, rd0_value_o);
    else pass_cnt++;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (rd0_o !== 5'(10 + i) || rd0_value_o !== 32'h100 + 32'(i) || mem_ready_o !== 1'b1) begin
        $display("FAIL drain%0d: rd0=%0d val=%h ready=%b, want %0d %h 1",
                 i, rd0_o, rd0_value_o, mem_ready_o, 10 + i, 32'h100 + 32'(i));
      end else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (rd0_o !== 5'd0) $display("FAIL drain_done: rd0=%0d, want 0", rd0_o);
    else pass_cnt++;
  endtask

  task automatic test_starvation();
    int n;
    exec_valid_i = 1'b1; exec_rd_i = 5'd3; exec_value_i = 32'h33;
    mem_valid_i  = 1'b1; mem_rd_i  = 5'd20; mem_value_i = 32'h55;
    tick();
    mem_valid_i = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (exec_stall_o === 1'b1) begin
        n = k;
        break;
      end
    end
    total_cnt++;
    if (n !== 8) $display("FAIL stall_latency: stall after %0d cycles, want 8", n);
    else pass_cnt++;
    total_cnt++;
    if (rd0_o !== 5'd3) $display("FAIL stall_exec_wins: rd0=%0d, want 3", rd0_o);
    else pass_cnt++;
    exec_valid_i = 1'b0;
    tick();
    total_cnt++;
    if (rd0_o !== 5'd20 || rd0_value_o !== 32'h55 || exec_stall_o !== 1'b0) begin
      $display("FAIL stall_release: rd0=%0d val=%h stall=%b, want 20 00000055 0",
               rd0_o, rd0_value_o, exec_stall_o);
    end else pass_cnt++;
    idle_inputs();
    tick();
  endtask

  task automatic test_pend_fwd();
    exec_valid_i = 1'b1; exec_rd_i = 5'd4; exec_value_i = 32'h44;
    mem_valid_i  = 1'b1; mem_rd_i  = 5'd9; mem_value_i = 32'h99;
    tick();
    mem_rd_i = 5'd0; mem_value_i = 32'h77;
    ra0_i = 5'd9; rb0_i = 5'd4; issue_rd_i = 5'd9;
    #1;
    total_cnt++;
    if (ra0_pend_o !== 1'b1 || rd_pend_o !== 1'b1 || rb0_pend_o !== 1'b0) begin
      $display("FAIL pend_hit: ra=%b rd=%b rb=%b, want 1 1 0", ra0_pend_o, rd_pend_o, rb0_pend_o);
    end else pass_cnt++;
    total_cnt++;
    if (rb0_fwd_o !== 1'b1 || ra0_fwd_o !== 1'b0) $display("FAIL fwd: rb=%b ra=%b, want 1 0", rb0_fwd_o, ra0_fwd_o);
    else pass_cnt++;
    tick();
    mem_valid_i = 1'b0;
    ra0_i = 5'd0; issue_rd_i = 5'd0;
    #1;
    total_cnt++;
    if (ra0_pend_o !== 1'b0 || rd_pend_o !== 1'b0) $display("FAIL pend_zero: ra=%b rd=%b, want 0 0", ra0_pend_o, rd_pend_o);
    else pass_cnt++;
    exec_valid_i = 1'b0;
    ra0_i = 5'd9;
    tick();
    total_cnt++;
    if (rd0_o !== 5'd9 || rd0_value_o !== 32'h99 || ra0_pend_o !== 1'b0 || ra0_fwd_o !== 1'b1) begin
      $display("FAIL pend_pop: rd0=%0d val=%h pend=%b fwd=%b, want 9 00000099 0 1",
               rd0_o, rd0_value_o, ra0_pend_o, ra0_fwd_o);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (rd0_o !== 5'd0) $display("FAIL rd0_dropped: rd0=%0d, want 0", rd0_o);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin
      exec_valid_i = 1'b1; exec_rd_i = 5'd2; exec_value_i = 32'h22;
      mem_valid_i  = 1'b1; mem_rd_i  = 5'(21 + i); mem_value_i = 32'(i);
      tick();
    end
    idle_inputs();
    ra0_i = 5'd21;
    #1;
    total_cnt++;
    if (mem_ready_o !== 1'b0 || ra0_pend_o !== 1'b1 || rd0_o !== 5'd2) begin
      $display("FAIL pre_reset: ready=%b pend=%b rd0=%0d, want 0 1 2", mem_ready_o, ra0_pend_o, rd0_o);
    end else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if (mem_ready_o !== 1'b1 || rd0_o !== 5'd0 || ra0_pend_o !== 1'b0) begin
      $display("FAIL async_reset: ready=%b rd0=%0d pend=%b, want 1 0 0", mem_ready_o, rd0_o, ra0_pend_o);
    end else pass_cnt++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (rd0_o !== 5'd0) $display("FAIL post_reset%0d: rd0=%0d, want 0", i, rd0_o);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_exec();
    test_mem_single();
    test_fifo_full();
    test_starvation();
    test_pend_fwd();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
